// File: rtl/ball_renderer.sv
// Ball renderer: latches the ball position once per frame, rasterises an 8x8 round sprite
// against the pixel stream (2-cycle latency) and reports a per-frame ball/paddle hit pulse.
module ball_renderer #(
    parameter logic [2:0] BALL_RGB = 3'b111,
    parameter logic [9:0] X_INIT   = 10'd200,
    parameter logic [9:0] Y_INIT   = 10'd300
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] ball_x,
    input  logic [9:0] ball_y,
    input  logic       frame_tick,
    input  logic [9:0] pixel_x,
    input  logic [9:0] pixel_y,
    input  logic       video_on,
    input  logic       paddle_on,
    output logic       ball_on,
    output logic [2:0] ball_rgb,
    output logic       hit
);

    typedef enum logic {FrameClean, FrameHit} hit_state_e;

    logic [9:0]  shadow_x_q, shadow_y_q;
    logic [10:0] dx, dy;
    logic        in_box;
    logic        in_box_d1_q;
    logic [2:0]  row_d1_q, col_d1_q;
    logic        paddle_d1_q, paddle_d2_q;
    logic [7:0]  rom_row;
    logic        pix_bit;
    logic        ball_on_q;
    logic [2:0]  ball_rgb_q;
    logic        overlap;
    hit_state_e  state_q, state_d;
    logic        hit_q, hit_d;

    // Position is only sampled on frame_tick so a frame never shows a torn ball.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shadow_x_q <= X_INIT;
            shadow_y_q <= Y_INIT;
        end else if (frame_tick) begin
            shadow_x_q <= ball_x;
            shadow_y_q <= ball_y;
        end
    end

    // 11-bit differences plus the >= compares keep the ball from wrapping to column 0.
    assign dx     = {1'b0, pixel_x} - {1'b0, shadow_x_q};
    assign dy     = {1'b0, pixel_y} - {1'b0, shadow_y_q};
    assign in_box = video_on & (pixel_x >= shadow_x_q) & (pixel_y >= shadow_y_q) &
                    (dx < 11'd8) & (dy < 11'd8);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            in_box_d1_q <= 1'b0;
            row_d1_q    <= 3'd0;
            col_d1_q    <= 3'd0;
            paddle_d1_q <= 1'b0;
        end else begin
            in_box_d1_q <= in_box;
            row_d1_q    <= dy[2:0];
            col_d1_q    <= dx[2:0];
            paddle_d1_q <= paddle_on;
        end
    end

    always_comb begin
        rom_row = 8'b11111111;
        case (row_d1_q)
            3'd0, 3'd7: rom_row = 8'b00111100;
            3'd1, 3'd6: rom_row = 8'b01111110;
            default:    rom_row = 8'b11111111;
        endcase
    end

    assign pix_bit = in_box_d1_q & rom_row[3'd7 - col_d1_q];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ball_on_q   <= 1'b0;
            ball_rgb_q  <= 3'b000;
            paddle_d2_q <= 1'b0;
        end else begin
            ball_on_q   <= pix_bit;
            ball_rgb_q  <= pix_bit ? BALL_RGB : 3'b000;
            paddle_d2_q <= paddle_d1_q;
        end
    end

    assign overlap = ball_on_q & paddle_d2_q;

    // Hit FSM: FrameHit remembers an overlap seen earlier in the current frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= FrameClean;
            hit_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hit_q   <= hit_d;
        end
    end

    always_comb begin
        state_d = state_q;
        hit_d   = 1'b0;
        if (frame_tick) begin
            hit_d   = (state_q == FrameHit) | overlap;
            state_d = FrameClean;
        end else if (overlap) begin
            state_d = FrameHit;
        end
    end

    always_comb begin
        ball_on  = ball_on_q;
        ball_rgb = ball_rgb_q;
        hit      = hit_q;
    end

endmodule

// File: tb/tb_ball_renderer.sv
// Self-checking bench for ball_renderer: directed probe table, hit/reset sequences and
// randomized traffic against a cycle-level behavioural model of the sprite and hit rules.
module tb_ball_renderer;

    logic       clk;
    logic       reset;
    logic [9:0] ball_x, ball_y;
    logic       frame_tick;
    logic [9:0] pixel_x, pixel_y;
    logic       video_on;
    logic       paddle_on;
    logic       ball_on;
    logic [2:0] ball_rgb;
    logic       hit;

    int n_checks = 0;
    int n_fail   = 0;

    ball_renderer dut (
        .clk        (clk),
        .reset      (reset),
        .ball_x     (ball_x),
        .ball_y     (ball_y),
        .frame_tick (frame_tick),
        .pixel_x    (pixel_x),
        .pixel_y    (pixel_y),
        .video_on   (video_on),
        .paddle_on  (paddle_on),
        .ball_on    (ball_on),
        .ball_rgb   (ball_rgb),
        .hit        (hit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got running, required finished");
        $fatal(1, "watchdog");
    end

    // Sprite shape, one byte per row, leftmost pixel in the MSB.
    logic [7:0] shape [8];
    initial begin
        shape[0] = 8'h3C; shape[1] = 8'h7E; shape[2] = 8'hFF; shape[3] = 8'hFF;
        shape[4] = 8'hFF; shape[5] = 8'hFF; shape[6] = 8'h7E; shape[7] = 8'h3C;
    end

    // Model state: latched position, 2-deep output delay line, frame hit flag.
    int m_sx, m_sy;
    bit d1_on, d1_pad, m_on, m_pad, m_seen, m_hit;

    function automatic bit ball_pix(int px, int py, bit vo, int sx, int sy);
        int c, r;
        if (!vo) return 1'b0;
        c = px - sx;
        r = py - sy;
        if (c < 0 || r < 0 || c > 7 || r > 7) return 1'b0;
        return shape[r][7 - c];
    endfunction

    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_sx = 200; m_sy = 300;
        d1_on = 0; d1_pad = 0; m_on = 0; m_pad = 0; m_seen = 0; m_hit = 0;
    endtask

    // Advance one clock with the currently driven inputs and compare against the model.
    task automatic step();
        bit nb, ov, nhit;
        nb = ball_pix(int'(pixel_x), int'(pixel_y), video_on, m_sx, m_sy);
        ov = m_on & m_pad;
        if (frame_tick) begin
            nhit   = m_seen | ov;
            m_seen = 0;
            m_sx   = int'(ball_x);
            m_sy   = int'(ball_y);
        end else begin
            nhit = 0;
            if (ov) m_seen = 1;
        end
        @(posedge clk);
        #1;
        m_on   = d1_on;
        m_pad  = d1_pad;
        d1_on  = nb;
        d1_pad = paddle_on;
        m_hit  = nhit;
        check("model_ball_on", int'(ball_on), int'(m_on));
        check("model_ball_rgb", int'(ball_rgb), m_on ? 7 : 0);
        check("model_hit", int'(hit), int'(m_hit));
    endtask

    task automatic idle_pixel();
        pixel_x = 10'd0; pixel_y = 10'd0; video_on = 1'b0; paddle_on = 1'b0;
    endtask

    task automatic do_tick(input int bx, input int by);
        ball_x = 10'(bx); ball_y = 10'(by); frame_tick = 1'b1;
        idle_pixel();
        step();
        frame_tick = 1'b0;
        ball_x = 10'($urandom); ball_y = 10'($urandom);
    endtask

    // Drive one pixel, then idle; ball_on reflects it after the second clock.
    task automatic probe(input int px, input int py, input bit vo, input bit pad,
                         input bit exp_on, input string name);
        pixel_x = 10'(px); pixel_y = 10'(py); video_on = vo; paddle_on = pad;
        step();
        idle_pixel();
        step();
        check({name, "_on"}, int'(ball_on), int'(exp_on));
        check({name, "_rgb"}, int'(ball_rgb), exp_on ? 7 : 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #3;
        check("async_reset_ball_on", int'(ball_on), 0);
        check("async_reset_hit", int'(hit), 0);
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    typedef struct {
        bit    tick;
        int    bx, by;
        int    px, py;
        bit    vo;
        bit    exp_on;
        string name;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input bit tick, input int bx, input int by, input int px, input int py,
                       input bit vo, input bit exp_on, input string name);
        vec_t v;
        v.tick = tick; v.bx = bx; v.by = by; v.px = px; v.py = py;
        v.vo = vo; v.exp_on = exp_on; v.name = name;
        vecs.push_back(v);
    endtask

    initial begin
        reset = 1'b1; frame_tick = 1'b0; ball_x = 10'd0; ball_y = 10'd0;
        idle_pixel();
        model_reset();
        #1;
        check("reset_ball_on", int'(ball_on), 0);
        check("reset_ball_rgb", int'(ball_rgb), 0);
        check("reset_hit", int'(hit), 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;

        add(0, 100, 50, 200, 300, 1, 0, "init_row0_col0");
        add(0, 100, 50, 203, 300, 1, 1, "init_row0_col3");
        add(0, 100, 50, 104, 53,  1, 0, "midframe_pos_ignored");
        add(0, 100, 50, 203, 301, 1, 1, "old_pos_kept");
        add(1, 100, 50, 104, 53,  1, 1, "new_pos_inside");
        add(0, 100, 50, 108, 53,  1, 0, "new_pos_right_edge");
        add(0, 100, 50, 100, 50,  1, 0, "new_pos_corner");
        add(0, 100, 50, 101, 51,  1, 1, "new_pos_row1_col1");
        add(0, 100, 50, 104, 53,  0, 0, "blanking_forces_off");
        for (int c = 1016; c <= 1027; c++) begin
            add(c == 1016, 1020, 10, c % 1024, 13, 1, (c >= 1020 && c <= 1023), "clip_scan");
        end

        foreach (vecs[i]) begin
            if (vecs[i].tick) begin
                do_tick(vecs[i].bx, vecs[i].by);
            end else begin
                ball_x = 10'(vecs[i].bx); ball_y = 10'(vecs[i].by);
            end
            probe(vecs[i].px, vecs[i].py, vecs[i].vo, 1'b0, vecs[i].exp_on, vecs[i].name);
        end

        // Overlap mid-frame, hit pulse lasts one cycle, next clean frame gives no hit.
        do_tick(200, 300);
        probe(203, 302, 1, 1, 1, "overlap_pixel");
        idle_pixel();
        step(); step();
        do_tick(200, 300);
        check("hit_after_overlap", int'(hit), 1);
        step();
        check("hit_one_cycle", int'(hit), 0);
        step();
        do_tick(200, 300);
        check("hit_clean_frame", int'(hit), 0);
        do_tick(200, 300);
        check("hit_back_to_back_tick", int'(hit), 0);

        // Overlap landing on the tick cycle closes the old frame.
        probe(203, 302, 1, 1, 1, "overlap_on_tick_pixel");
        do_tick(200, 300);
        check("hit_overlap_on_tick", int'(hit), 1);
        step();
        do_tick(200, 300);
        check("hit_after_tick_overlap", int'(hit), 0);

        // Reset while a hit is pending drops it and restores the initial position.
        do_tick(400, 100);
        probe(403, 102, 1, 1, 1, "pre_reset_overlap");
        step(); step();
        do_reset();
        probe(203, 300, 1, 0, 1, "post_reset_init_pos");
        probe(403, 102, 1, 0, 0, "post_reset_old_pos_gone");
        do_tick(400, 100);
        check("hit_after_reset", int'(hit), 0);

        // Randomised traffic around the ball with occasional frame ticks and paddle pixels.
        for (int i = 0; i < 3000; i++) begin
            int px, py;
            px = (m_sx + int'($urandom_range(0, 11)) - 2) & 1023;
            py = (m_sy + int'($urandom_range(0, 11)) - 2) & 1023;
            pixel_x   = 10'(px);
            pixel_y   = 10'(py);
            video_on  = ($urandom % 8) != 0;
            paddle_on = ($urandom % 3) == 0;
            frame_tick = ($urandom % 24) == 0;
            if (frame_tick) begin
                ball_x = 10'($urandom_range(0, 1023));
                ball_y = 10'($urandom_range(0, 520));
            end else begin
                ball_x = 10'($urandom); ball_y = 10'($urandom);
            end
            step();
        end
        frame_tick = 1'b0;
        idle_pixel();
        step(); step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ball_renderer.md
Name: ball_renderer

Overview:
Consumer end of the ball position interface (ball_x/ball_y) driven by the ball animation block.
- Latches the position once per frame and rasterises an 8x8 round ball against the VGA pixel stream.
- Outputs a ball-pixel flag and colour for the RGB mux.
- Reports a one-cycle per-frame hit pulse back to the animation/game logic when a ball pixel overlapped a paddle pixel during the frame.

Parameters:
BALL_RGB, 3'b111, colour driven on ball_rgb for ball pixels
X_INIT, 10'd200, shadow ball x after reset
Y_INIT, 10'd300, shadow ball y after reset

Ports:
clk  input  1  pixel clock
reset  input  1  asynchronous, active-high reset
ball_x  input  10  ball left column from animation block
ball_y  input  10  ball top row from animation block
frame_tick  input  1  one-cycle pulse at start of vertical blanking
pixel_x  input  10  current pixel column from sync generator
pixel_y  input  10  current pixel row from sync generator
video_on  input  1  visible-region flag, aligned with pixel_x/pixel_y
paddle_on  input  1  paddle pixel flag, aligned with pixel_x/pixel_y
ball_on  output  1  ball pixel, 2-cycle latency vs pixel inputs
ball_rgb  output  3  BALL_RGB when ball_on, else 3'b000
hit  output  1  one-cycle pulse: overlap occurred in frame just ended

Behaviour:
- One clock domain: clk. Reset is asynchronous, active-high.
- Reset values:
  - shadow_x = X_INIT, shadow_y = Y_INIT.
  - All pipeline registers, ball_on, ball_rgb, hit and hit_seen = 0.
- Position latch:
  - On a cycle with frame_tick=1, shadow_x/shadow_y <= ball_x/ball_y.
  - ball_x/ball_y are ignored on all other cycles, so a mid-frame position change never tears the image.
- Stage 1, registered:
  - dx = pixel_x - shadow_x, dy = pixel_y - shadow_y, both computed 11-bit.
  - in_box = video_on & (pixel_x >= shadow_x) & (pixel_y >= shadow_y) & (dx < 8) & (dy < 8).
  - Register in_box, row = dy[2:0], col = dx[2:0], and paddle_on.
  - No wrap-around: a ball with shadow_x > 1016 is clipped at column 1023, never drawn at column 0.
- Stage 2, registered:
  - ROM rows 0..7 = 00111100, 01111110, 11111111, 11111111, 11111111, 11111111, 01111110, 00111100.
  - col 0 selects the MSB.
  - ball_on <= in_box_d1 & rom[row][7-col].
  - ball_rgb <= BALL_RGB if set, else 0.
  - paddle_d2 <= paddle_d1.
  - Total latency from pixel inputs to ball_on/ball_rgb: 2 clocks.
- Overlap: overlap = ball_on & paddle_d2, where ball_on is the registered stage-2 output.
- Hit state machine (FRAME_CLEAN / FRAME_HIT, encoded by hit_seen):
  - FRAME_CLEAN -> FRAME_HIT on overlap=1.
  - On frame_tick: hit <= hit_seen | overlap, then return to FRAME_CLEAN.
  - Overlap in the same cycle as frame_tick counts toward the frame being closed, not the new one.
  - hit is 0 on every cycle following a non-tick cycle.
  - Back-to-back frame_tick pulses give hit=0 on the second pulse unless an overlap occurs in that cycle.
- Reset mid-frame:
  - All state clears immediately.
  - The shadow position stays at X_INIT/Y_INIT until the next frame_tick.
  - The first hit pulse after reset reflects only post-reset overlaps.
- Pixels flow through the pipeline during blanking; video_on=0 forces in_box=0.

Test Plan:
- Reset, no frame_tick, pixel (200,300) visible -> ball_on=0 two cycles later (ROM row0 col0 = 0); pixel (203,300) -> ball_on=1, ball_rgb=3'b111 exactly 2 cycles after input.
- ball_x=100, ball_y=50 applied mid-frame without frame_tick -> render unchanged at (200,300); after a frame_tick pulse, pixel (104,53) -> ball_on=1 and (108,53) -> ball_on=0.
- ball_x=1020, ball_y=10, after frame_tick, scan row 13 across columns 1016..1023 and 0..3 -> ball_on only at columns 1020..1023, never at 0..3.
- paddle_on=1 at pixel (203,302) inside the ball during a frame, then frame_tick -> hit=1 for exactly one cycle; next frame with no overlap -> hit=0 at its frame_tick.
- Overlap in the same cycle as the frame_tick pulse -> hit=1 on that tick; following frame with no overlap -> hit=0.
- Assert reset while hit_seen=1 mid-frame, release, no further overlap -> hit=0 at next frame_tick; shadow position = (200,300) until that tick.
